div_hilo_ctrl: RTL and testbench
================================

// Module: div_hilo_ctrl
// PURPOSE
//  Multi-cycle unsigned divide controller that feeds the HiLo register.
//  - Accepts a start pulse with 32-bit dividend/divisor.
//  - Runs a restoring shift-subtract divide, one bit per clock.
//  - Drives the packed 64-bit result plus a one-cycle write enable into HiLo's DivAns input.
//  - Sits between the ALU issue logic and HiLo; busy stalls further divide/mfhi/mflo issue.
// PARAMETERS
//  WIDTH  32  operand width; div_ans is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  reset        in   1        synchronous, active-high reset
//  start        in   1        request; sampled only in IDLE
//  dividend     in   WIDTH    unsigned dividend, sampled with start
//  divisor      in   WIDTH    unsigned divisor, sampled with start
//  busy         out  1        high in RUN state
//  done         out  1        one-cycle pulse in DONE state
//  div_by_zero  out  1        sticky flag: last accepted op had divisor==0
//  hilo_we      out  1        one-cycle write strobe to HiLo, equal to done
//  div_ans      out  2*WIDTH  {quotient, remainder}; [WIDTH-1:0]=remainder (Hi), [2W-1:W]=quotient (Lo)
// BEHAVIOUR
//  - Reset: clk, reset synchronous, active-high. State=IDLE; busy, done, hilo_we, div_by_zero = 0; div_ans = 0; counter = 0.
//  - States: IDLE, RUN, DONE.
//  - IDLE, start=1, divisor!=0:
//    - latch operands: rem=0 (WIDTH+1 bits), quot=dividend, dvsr=divisor, cnt=WIDTH;
//    - clear div_by_zero; go RUN.
//  - IDLE, start=1, divisor==0:
//    - no iterations; set div_by_zero=1;
//    - load div_ans={ {WIDTH{1'b1}}, dividend } directly; go DONE.
//  - RUN: per edge, trial = {rem[W-1:0], quot[W-1]} - {1'b0, dvsr}.
//    - trial non-negative (MSB 0): rem=trial, quot={quot[W-2:0],1}.
//    - otherwise: rem={rem[W-1:0],quot[W-1]}, quot={quot[W-2:0],0}.
//    - cnt decrements; when cnt reaches 1 this edge performs the final iteration.
//    - Same edge: div_ans <= {quot_next, rem_next[W-1:0]}; go DONE.
//  - DONE: done=1, hilo_we=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  - Latency: start sampled at edge E0 -> done high in the cycle after edge E_WIDTH (WIDTH+1 cycles); divide-by-zero -> done in the cycle after E0 (1 cycle).
//  - Throughput: next start accepted in the IDLE cycle following DONE; min issue interval WIDTH+2 cycles.
//  - start while RUN or DONE is ignored; operands are not re-sampled.
//  - div_ans changes only on the transition into DONE; it holds between ops, so HiLo rewrites are idempotent.
//  - Operand inputs may change freely after the start cycle.
//  - reset during RUN or DONE: abort immediately to reset values.
//    - No done/hilo_we is generated for the aborted op.
//    - div_ans is cleared, matching HiLo clearing on the same reset.
//  - Arithmetic is unsigned only; sign handling is the issuer's job.
//  - Carry/borrow tracked in a WIDTH+1 subtractor; no truncation of intermediate rem.
//  - Outputs busy/done/hilo_we decode from the registered state (no combinational path from start).
// STRUCTURE
//  - Shared package div_pkg:
//    - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//    - DIV_WIDTH=32;
//    - HILO_HI_LSB=0, HILO_LO_LSB=32 packing constants (also used by HiLo readers).
//  - One sub-module, div_step: purely combinational single restoring iteration.
//    - Inputs: rem, quot, dvsr. Outputs: rem_next, quot_next.
//    - Instantiated once; the controller owns the FSM, counter and registers.
// TESTING
//  - 100/7: start pulse -> busy for 32 cycles; done+hilo_we on cycle 33; div_ans=64'h0000000E_00000002, div_by_zero=0.
//  - 5/0: start -> done in the next cycle; div_ans=64'hFFFFFFFF_00000005, div_by_zero=1, busy never high.
//  - FFFFFFFF/1 -> div_ans=64'hFFFFFFFF_00000000.
//  - 3/FFFFFFFF -> div_ans=64'h00000000_00000003.
//  - Hold start=1 with new operands throughout RUN -> first op's result only.
//    - Second op starts in the IDLE cycle after DONE; exactly one hilo_we per accepted op.
//  - reset asserted at RUN cycle 10 -> next cycle all outputs 0, state IDLE, no hilo_we.
//    - A new 100/7 afterwards completes normally in 33 cycles.
//  - Scoreboard: random 1000 ops with ~5% zero divisors vs the reference model (a/b, a%b).
//    - Check div_ans only when hilo_we=1 and that it is stable otherwise.

Source files
------------

// File: rtl/div_pkg.sv
// Shared divider constants: state encoding, operand width and HiLo packing.
// HiLo readers pick Hi/Lo out of div_ans with the same offsets.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int HILO_HI_LSB = 0;
  localparam int HILO_LO_LSB = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration, purely combinational.
// The borrow lives in the WIDTH+1 trial; a kept remainder is always < dvsr.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_next  = trial[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_next  = shifted[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_hilo_ctrl.sv
// Multi-cycle unsigned divide controller feeding HiLo's DivAns port.
// One quotient bit per clock; divide-by-zero short-circuits to DONE.
module div_hilo_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               hilo_we,
  output logic [2*WIDTH-1:0] div_ans
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e     state;
  div_state_e     state_next;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic           last;

  assign last = (cnt == CW'(1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .dvsr      (dvsr),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_next = (divisor == '0) ? S_DONE : S_RUN;
      end
      S_RUN:  if (last) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem         <= '0;
      quot        <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
      div_ans     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && divisor == '0) begin
            div_by_zero <= 1'b1;
            div_ans[HILO_LO_LSB +: WIDTH] <= '1;
            div_ans[HILO_HI_LSB +: WIDTH] <= dividend;
          end else if (start) begin
            rem         <= '0;
            quot        <= dividend;
            dvsr        <= divisor;
            cnt         <= CW'(WIDTH);
            div_by_zero <= 1'b0;
          end
        end
        S_RUN: begin
          rem  <= rem_next;
          quot <= quot_next;
          cnt  <= cnt - CW'(1);
          if (last) begin
            div_ans[HILO_LO_LSB +: WIDTH] <= quot_next;
            div_ans[HILO_HI_LSB +: WIDTH] <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign hilo_we = done;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl: directed corners plus
// a random scoreboard against plain a/b, a%b arithmetic.
module tb_div_hilo_ctrl;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        hilo_we;
  logic [63:0] div_ans;

  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] prev_ans = '0;

  always #5 clk = ~clk;

  div_hilo_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hilo_we     (hilo_we),
    .div_ans     (div_ans)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_ans(input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after DONE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int lat, nbusy, nwe;
    logic got, unstable;
    exp = ref_ans(a, b);
    lat = 0; nbusy = 0; nwe = 0;
    got = 1'b0; unstable = 1'b0;
    start = 1'b1; dividend = a; divisor = b;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
      end
      if (busy) nbusy++;
      if (hilo_we) nwe++;
      if (done) got = 1'b1;
      else if (div_ans !== prev_ans) unstable = 1'b1;
    end
    chk("timeout", got, 1);
    chk("latency", lat, (b == 0) ? 1 : 33);
    chk("busy_cycles", nbusy, (b == 0) ? 0 : 32);
    chk("we_count", nwe, 1);
    chk("div_ans", div_ans, exp);
    chk("div_by_zero", div_by_zero, (b == 0));
    chk("stable", unstable, 0);
    prev_ans = exp;
    @(negedge clk);
    chk("idle_after", {busy, done, hilo_we}, 0);
    chk("hold_ans", div_ans, exp);
  endtask

  initial begin
    int lat, nwe;
    logic got;
    logic [31:0] a, b;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_ans", div_ans, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(32'd100, 32'd7);
    chk("ans_100_7", div_ans, 64'h0000000E_00000002);
    do_op(32'd5, 32'd0);
    chk("ans_5_0", div_ans, 64'hFFFFFFFF_00000005);
    do_op(32'hFFFF_FFFF, 32'd1);
    do_op(32'd3, 32'hFFFF_FFFF);

    // start held high with shifting operands through RUN
    start = 1'b1; dividend = 100; divisor = 7;
    lat = 0; nwe = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      dividend = $urandom;
      divisor = $urandom | 32'd1;
      if (hilo_we) nwe++;
      if (done) got = 1'b1;
    end
    chk("hold1_lat", lat, 33);
    chk("hold1_ans", div_ans, 64'h0000000E_00000002);
    dividend = 9; divisor = 4;
    @(negedge clk);
    chk("hold_idle", {busy, done}, 0);
    @(negedge clk);
    start = 1'b0;
    chk("hold2_busy", busy, 1);
    lat = 1; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (hilo_we) nwe++;
      if (done) got = 1'b1;
    end
    chk("hold2_lat", lat, 33);
    chk("hold2_ans", div_ans, 64'h00000002_00000001);
    chk("hold_we_count", nwe, 2);
    prev_ans = 64'h00000002_00000001;
    @(negedge clk);

    // reset in the middle of RUN
    start = 1'b1; dividend = 100; divisor = 7;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
    end
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_outs", {busy, done, hilo_we, div_by_zero}, 0);
    chk("abort_ans", div_ans, 0);
    prev_ans = '0;
    nwe = 0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) nwe++;
    end
    chk("abort_no_we", nwe, 0);
    do_op(32'd100, 32'd7);

    repeat (1000) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 0) b = 32'd1;
      if ($urandom_range(0, 19) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) a = b * $urandom_range(0, 5);
      do_op(a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
